// File: rtl/wshb_arbiter2.sv
// Two-master Wishbone arbiter feeding the RAM controller.
// Round-robin on ties, burst lock on cyc, watchdog on stalled strobes.
module wshb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_ms,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic [DATA_WIDTH-1:0]   m0_dat_sm,
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_ms,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic [DATA_WIDTH-1:0]   m1_dat_sm,
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [DATA_WIDTH-1:0]   s_dat_ms,
  output logic [DATA_WIDTH/8-1:0] s_sel,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [DATA_WIDTH-1:0]   s_dat_sm,
  output logic [1:0]              grant
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;

  logic                  o_cyc;
  logic                  o_stb;
  logic                  o_we;
  logic [ADDR_WIDTH-1:0] o_adr;
  logic [DATA_WIDTH-1:0] o_dat;
  logic [SW-1:0]         o_sel;
  logic                  own0;
  logic                  own1;
  logic                  wdog_err;
  logic                  unused_rty;

  assign unused_rty = s_rty;
  assign own0 = (state_q == GNT0);
  assign own1 = (state_q == GNT1);

  // Owner mux: everything is zero while nobody holds the bus.
  always_comb begin
    o_cyc = 1'b0;
    o_stb = 1'b0;
    o_we  = 1'b0;
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    unique case (1'b1)
      own0: begin
        o_cyc = m0_cyc;
        o_stb = m0_stb;
        o_we  = m0_we;
        o_adr = m0_adr;
        o_dat = m0_dat_ms;
        o_sel = m0_sel;
      end
      own1: begin
        o_cyc = m1_cyc;
        o_stb = m1_stb;
        o_we  = m1_we;
        o_adr = m1_adr;
        o_dat = m1_dat_ms;
        o_sel = m1_sel;
      end
      default: ;
    endcase
  end

  // Ack in the same cycle suppresses the watchdog.
  assign wdog_err = (own0 | own1) & o_stb & ~s_ack
                  & (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      GNT0: begin
        if (!m0_cyc) state_d = IDLE;
      end
      GNT1: begin
        if (!m1_cyc) state_d = IDLE;
      end
      default: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
    endcase
    if (state_q == IDLE || !o_stb || s_ack || wdog_err)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_cyc    = o_cyc;
  assign s_stb    = o_stb & ~wdog_err;
  assign s_we     = o_we;
  assign s_adr    = o_adr;
  assign s_dat_ms = o_dat;
  assign s_sel    = o_sel;

  assign m0_ack    = own0 & s_ack;
  assign m0_err    = own0 & (s_err | wdog_err);
  assign m0_dat_sm = own0 ? s_dat_sm : '0;
  assign m1_ack    = own1 & s_ack;
  assign m1_err    = own1 & (s_err | wdog_err);
  assign m1_dat_sm = own1 ? s_dat_sm : '0;

  assign grant = {own1, own0};

endmodule

// File: tb/tb_wshb_arbiter2.sv
// Bench for wshb_arbiter2: per-cycle model compare plus
// directed scenarios with literal expectations.
module tb_wshb_arbiter2;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_ms;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;
  logic [31:0] m0_dat_sm;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_ms;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;
  logic [31:0] m1_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_ms;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat_sm;
  logic [1:0]  grant;

  int total = 0;
  int bad = 0;

  wshb_arbiter2 #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
    .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
    .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
    .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .s_dat_sm(s_dat_sm), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, who won last, length of current stall streak.
  int own = -1;
  int last = 1;
  int streak = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = -1;
      last = 1;
      streak = 0;
    end else if (own < 0) begin
      if (m0_cyc && m1_cyc) own = 1 - last;
      else if (m0_cyc) own = 0;
      else if (m1_cyc) own = 1;
      if (own >= 0) last = own;
      streak = 0;
    end else begin
      if (!(own == 0 ? m0_cyc : m1_cyc)) begin
        own = -1;
        streak = 0;
      end else if ((own == 0 ? m0_stb : m1_stb) && !s_ack) begin
        streak++;
      end else begin
        streak = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic        ec, es, ew, wd;
    logic [31:0] ea, ed;
    logic [3:0]  el;
    ec = 0; es = 0; ew = 0; ea = 0; ed = 0; el = 0;
    if (own == 0) begin
      ec = m0_cyc; es = m0_stb; ew = m0_we;
      ea = m0_adr; ed = m0_dat_ms; el = m0_sel;
    end else if (own == 1) begin
      ec = m1_cyc; es = m1_stb; ew = m1_we;
      ea = m1_adr; ed = m1_dat_ms; el = m1_sel;
    end
    wd = (own >= 0) && es && !s_ack && (streak % TO == TO - 1);
    chk("m_grant", grant, own < 0 ? 2'b00 : (own == 0 ? 2'b01 : 2'b10));
    chk("m_s_cyc", s_cyc, ec);
    chk("m_s_stb", s_stb, es & ~wd);
    chk("m_s_we", s_we, ew);
    chk("m_s_adr", s_adr, ea);
    chk("m_s_dat", s_dat_ms, ed);
    chk("m_s_sel", s_sel, el);
    chk("m_m0_ack", m0_ack, own == 0 && s_ack);
    chk("m_m1_ack", m1_ack, own == 1 && s_ack);
    chk("m_m0_err", m0_err, own == 0 && (s_err || wd));
    chk("m_m1_err", m1_err, own == 1 && (s_err || wd));
    chk("m_m0_dat", m0_dat_sm, own == 0 ? s_dat_sm : 32'h0);
    chk("m_m1_dat", m1_dat_sm, own == 1 ? s_dat_sm : 32'h0);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m0_adr = 0; m0_dat_ms = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    m1_adr = 0; m1_dat_ms = 0; m1_sel = 0;
    s_ack = 0; s_err = 0; s_rty = 0; s_dat_sm = 0;
  endtask

  task automatic do_reset();
    idle_all();
    step(1);
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(1);
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    step(2);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m0_ack", m0_ack, 1'b0);
    rst_n = 1;
    step(1);

    // Single m0 request and an 8-beat burst read.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h10;
    m1_adr = 32'h999;
    step(1);
    chk("r028_grant", grant, 2'b01);
    chk("r028_adr", s_adr, 32'h10);
    for (int i = 0; i < 8; i++) begin
      s_ack = 1; s_dat_sm = 32'hA0 + i;
      #1;
      chk("r028_ack0", m0_ack, 1'b1);
      chk("r028_ack1", m1_ack, 1'b0);
      chk("r028_dat", m0_dat_sm, 32'hA0 + i);
      step(1);
    end
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step(1);
    chk("r028_rel", grant, 2'b00);

    // Tie after reset, then alternation.
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h40;
    step(1);
    chk("r029_tie1", grant, 2'b01);
    s_ack = 1;
    step(1);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    step(1);
    chk("r029_gap", grant, 2'b00);
    chk("r029_gapcyc", s_cyc, 1'b0);
    step(1);
    chk("r029_m1", grant, 2'b10);
    chk("r029_m1adr", s_adr, 32'h40);
    s_ack = 1;
    step(1);
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step(1);
    chk("r029_gap2", grant, 2'b00);
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step(1);
    chk("r029_tie2", grant, 2'b01);

    // m0 holds cyc with stb low; m1 write waits.
    do_reset();
    m0_cyc = 1; m0_stb = 0;
    step(1);
    m1_cyc = 1; m1_stb = 1; m1_we = 1;
    m1_dat_ms = 32'hDEADBEEF; m1_sel = 4'hF;
    step(6);
    chk("r030_hold", grant, 2'b01);
    chk("r030_stb", s_stb, 1'b0);
    chk("r030_err", m0_err, 1'b0);
    m0_cyc = 0;
    step(1);
    chk("r030_gap", grant, 2'b00);
    step(1);
    chk("r030_m1", grant, 2'b10);
    chk("r030_dat", s_dat_ms, 32'hDEADBEEF);
    chk("r030_sel", s_sel, 4'hF);
    chk("r030_we", s_we, 1'b1);
    s_ack = 1;
    step(1);
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    step(1);

    // Watchdog: no ack for TO cycles.
    do_reset();
    m1_cyc = 1; m1_stb = 1;
    step(1);
    for (int k = 1; k <= 5; k++) begin
      chk("r031_err", m1_err, k == 4);
      chk("r031_stb", s_stb, k != 4);
      chk("r031_ack", m1_ack, 1'b0);
      chk("r031_err0", m0_err, 1'b0);
      step(1);
    end
    step(2);
    s_ack = 1;
    #1;
    chk("r024_err", m1_err, 1'b0);
    chk("r024_ack", m1_ack, 1'b1);
    step(1);
    s_ack = 0; s_err = 1;
    #1;
    chk("s_err_fwd", m1_err, 1'b1);
    s_rty = 1;
    step(1);
    s_err = 0; s_rty = 0; m1_cyc = 0; m1_stb = 0;
    step(1);

    // Asynchronous reset in the middle of a burst.
    do_reset();
    m0_cyc = 1; m0_stb = 1;
    step(1);
    s_ack = 1;
    step(2);
    #1;
    rst_n = 0;
    #1;
    chk("r032_grant", grant, 2'b00);
    chk("r032_cyc", s_cyc, 1'b0);
    chk("r032_ack", m0_ack, 1'b0);
    s_ack = 0; m1_cyc = 1; m1_stb = 1;
    step(1);
    rst_n = 1;
    step(1);
    chk("r032_tie", grant, 2'b01);

    // Mixed traffic, model-checked every cycle.
    for (int i = 0; i < 400; i++) begin
      m0_cyc = ($urandom_range(0, 9) != 0) ? m0_cyc ^ ($urandom_range(0, 5) == 0) : 1'b0;
      m0_stb = m0_cyc & $urandom_range(0, 1);
      m0_we = $urandom_range(0, 1);
      m0_adr = $urandom; m0_dat_ms = $urandom;
      m0_sel = 4'($urandom);
      m1_cyc = m1_cyc ^ ($urandom_range(0, 4) == 0);
      m1_stb = m1_cyc & ($urandom_range(0, 3) != 0);
      m1_we = $urandom_range(0, 1);
      m1_adr = $urandom; m1_dat_ms = $urandom;
      m1_sel = 4'($urandom);
      s_ack = ($urandom_range(0, 4) == 0);
      s_err = ($urandom_range(0, 15) == 0);
      s_rty = $urandom_range(0, 1);
      s_dat_sm = $urandom;
      step(1);
    end

    idle_all();
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
